// File: rtl/rv32i_types.sv
// Shared RV32I definitions: store funct3 encodings plus the store buffer's entry
// layout and drain FSM states.
package rv32i_types;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } store_buf_entry_t;

    typedef enum logic {
        SB_IDLE  = 1'b0,
        SB_WRITE = 1'b1
    } store_buf_state_t;

endpackage

// File: rtl/store_encode.sv
// Turns a raw store (funct3, low address bits, rs2 value) into a lane byte mask and
// lane-shifted data; flags misaligned halfword/word stores and non-store funct3.
module store_encode
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic        err
);

    always_comb begin
        wmask = 4'b0000;
        wdata = 32'h0;
        err   = 1'b0;
        case (funct3)
            F3_SB: begin
                wmask = 4'b0001 << addr_lo;
                wdata = {24'h0, data[7:0]} << {addr_lo, 3'b000};
            end
            F3_SH: begin
                if (addr_lo[0]) begin
                    err = 1'b1;
                end else begin
                    wmask = 4'b0011 << addr_lo;
                    wdata = {16'h0, data[15:0]} << {addr_lo[1], 4'b0000};
                end
            end
            F3_SW: begin
                if (addr_lo != 2'b00) begin
                    err = 1'b1;
                end else begin
                    wmask = 4'b1111;
                    wdata = data;
                end
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Post-commit store FIFO: encodes committed stores, drains them in order to dmem and
// answers combinational load-forwarding lookups against the queued entries.
module store_buffer
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [31:0]                enq_addr,
    input  logic [2:0]                 enq_funct3,
    input  logic [31:0]                enq_data,
    output logic                       enq_err,
    output logic [31:0]                dmem_addr,
    output logic [3:0]                 dmem_wmask,
    output logic [31:0]                dmem_wdata,
    input  logic                       dmem_resp,
    input  logic [31:0]                ld_addr,
    input  logic [3:0]                 ld_rmask,
    output logic                       fwd_hit,
    output logic                       fwd_conflict,
    output logic [3:0]                 fwd_wmask,
    output logic [31:0]                fwd_wdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    store_buf_entry_t mem [DEPTH];
    store_buf_state_t state_q;
    logic [AW-1:0]    head_q;
    logic [AW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_next;

    logic [3:0]       enc_wmask;
    logic [31:0]      enc_wdata;
    logic             enc_err;
    logic             enq_fire;
    logic             enq_push;
    logic             pop;

    store_encode u_encode (
        .funct3  (enq_funct3),
        .addr_lo (enq_addr[1:0]),
        .data    (enq_data),
        .wmask   (enc_wmask),
        .wdata   (enc_wdata),
        .err     (enc_err)
    );

    // Full refuses the offer even if the head retires this same cycle.
    assign enq_ready = (count_q != CW'(DEPTH));
    assign enq_fire  = enq_valid && enq_ready;
    assign enq_push  = enq_fire && !enc_err;
    assign pop       = (state_q == SB_WRITE) && dmem_resp;

    always_comb begin
        count_next = count_q;
        if (enq_push && !pop) begin
            count_next = count_q + CW'(1);
        end else if (!enq_push && pop) begin
            count_next = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (enq_push) begin
            mem[tail_q] <= '{waddr: enq_addr[31:2], wmask: enc_wmask, wdata: enc_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SB_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            enq_err <= 1'b0;
        end else begin
            count_q <= count_next;
            enq_err <= enq_fire && enc_err;
            if (enq_push) begin
                tail_q <= tail_q + AW'(1);
            end
            if (pop) begin
                head_q <= head_q + AW'(1);
            end
            case (state_q)
                SB_IDLE: begin
                    if (count_q != '0) begin
                        state_q <= SB_WRITE;
                    end
                end
                SB_WRITE: begin
                    if (pop && count_next == '0) begin
                        state_q <= SB_IDLE;
                    end
                end
                default: state_q <= SB_IDLE;
            endcase
        end
    end

    // The request is a view of the registered head, so reset clears it at once.
    assign dmem_wmask = (state_q == SB_WRITE) ? mem[head_q].wmask : 4'b0000;
    assign dmem_addr  = (state_q == SB_WRITE) ? {mem[head_q].waddr, 2'b00} : 32'h0;
    assign dmem_wdata = (state_q == SB_WRITE) ? mem[head_q].wdata : 32'h0;

    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign dbg_state = (state_q == SB_WRITE);

    logic             found;
    store_buf_entry_t sel;
    logic [AW-1:0]    idx;
    logic             unused_ld_lo;

    assign unused_ld_lo = ^ld_addr[1:0];

    // Walk oldest to youngest so the last overlapping match is the youngest store.
    always_comb begin
        found        = 1'b0;
        sel          = '0;
        idx          = '0;
        fwd_hit      = 1'b0;
        fwd_conflict = 1'b0;
        fwd_wmask    = 4'b0000;
        fwd_wdata    = 32'h0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + AW'(k);
            if ((CW'(k) < count_q) && (mem[idx].waddr == ld_addr[31:2]) &&
                ((mem[idx].wmask & ld_rmask) != 4'b0000)) begin
                found = 1'b1;
                sel   = mem[idx];
            end
        end
        if (found) begin
            if ((ld_rmask & ~sel.wmask) == 4'b0000) begin
                fwd_hit   = 1'b1;
                fwd_wmask = sel.wmask;
                fwd_wdata = sel.wdata;
            end else begin
                fwd_conflict = 1'b1;
            end
        end
    end

endmodule
